// File: rtl/tx_dpdm.sv
// tx_dpdm: USB D+/D- line transmitter.
// A start request puts SYNC (KJKJKJKK) on the bus. The packet bits follow,
// one per cycle, with 1 driven as J and 0 as K. The bits arrive already
// NRZI-encoded and bit-stuffed. The packet ends with EOP (SE0, SE0, J), and
// then the bus is released.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      packet request, sampled only in IDLE
//   s_in       packet bit (1 -> J, 0 -> K)
//   s_valid    s_in is valid
//   s_last     s_in is the final packet bit
//   s_ready    a bit is accepted on an edge where s_valid & s_ready
//   bus_out    line state: J=2'b10, K=2'b01, SE0=2'b00 (registered)
//   bus_en     drive bus_out onto D+/D- (registered)
//   busy       state != IDLE
//   complete   one-cycle pulse after the bus is released (registered)
//   pkt_error  qualifies complete: underrun or truncation (registered)
//
// state | meaning
// IDLE  | bus released, waiting for start
// SYNC  | driving SYNC symbols 1..7
// DATA  | accepting packet bits
// EOP1  | first SE0 of EOP
// EOP2  | second SE0 (an underrun abort enters here directly)
// EOPJ  | trailing J of EOP
// REL   | release bus, pulse complete
module tx_dpdm #(
  parameter int MAX_BITS = 88
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_in,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [1:0] bus_out,
  output logic       bus_en,
  output logic       busy,
  output logic       complete,
  output logic       pkt_error
);

  localparam int CW = $clog2(MAX_BITS + 1);

  localparam logic [1:0] SYM_J = 2'b10;
  localparam logic [1:0] SYM_K = 2'b01;
  localparam logic [1:0] SYM_X = 2'b00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    EOP1 = 3'd3,
    EOP2 = 3'd4,
    EOPJ = 3'd5,
    REL  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [1:0]    bus_q, bus_d;
  logic          en_q, en_d;
  logic          complete_q, complete_d;
  logic          pkt_error_q, pkt_error_d;

  logic          last_slot;
  logic [1:0]    sync_sym;

  // The SYNC pattern KJKJKJKK has J only at positions 1, 3 and 5.
  assign sync_sym  = (idx_q == 3'd1 || idx_q == 3'd3 || idx_q == 3'd5) ? SYM_J : SYM_K;
  assign last_slot = (cnt_q == CW'(MAX_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      bus_q       <= SYM_J;
      en_q        <= 1'b0;
      complete_q  <= 1'b0;
      pkt_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      bus_q       <= bus_d;
      en_q        <= en_d;
      complete_q  <= complete_d;
      pkt_error_q <= pkt_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = SYNC;
      SYNC: if (idx_q == 3'd7) state_d = DATA;
      DATA: begin
        if (!s_valid)                 state_d = EOP2;
        else if (s_last || last_slot) state_d = EOP1;
      end
      EOP1: state_d = EOP2;
      EOP2: state_d = EOPJ;
      EOPJ: state_d = REL;
      REL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic (values loaded at the next edge)
  always_comb begin
    bus_d       = bus_q;
    en_d        = en_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    complete_d  = 1'b0;
    pkt_error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus_d = SYM_J;
        en_d  = 1'b0;
        if (start) begin
          bus_d = SYM_K;
          en_d  = 1'b1;
          idx_d = 3'd1;
        end
      end
      SYNC: begin
        bus_d = sync_sym;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) cnt_d = '0;
      end
      DATA: begin
        if (s_valid) begin
          bus_d = s_in ? SYM_J : SYM_K;
          cnt_d = cnt_q + CW'(1);
          if (!s_last && last_slot) err_d = 1'b1;
        end else begin
          // Underrun: the SE0 loaded here plus EOP2 gives a 2-cycle SE0 abort.
          bus_d = SYM_X;
          err_d = 1'b1;
        end
      end
      EOP1: bus_d = SYM_X;
      EOP2: bus_d = SYM_X;
      EOPJ: bus_d = SYM_J;
      REL: begin
        bus_d       = SYM_J;
        en_d        = 1'b0;
        complete_d  = 1'b1;
        pkt_error_d = err_q;
        err_d       = 1'b0;
      end
      default: begin
        bus_d = SYM_J;
        en_d  = 1'b0;
      end
    endcase
  end

  assign s_ready   = (state_q == DATA);
  assign busy      = (state_q != IDLE);
  assign bus_out   = bus_q;
  assign bus_en    = en_q;
  assign complete  = complete_q;
  assign pkt_error = pkt_error_q;

endmodule

// File: tb/tb_tx_dpdm.sv
// Testbench for tx_dpdm. Each scenario pushes the bus symbols it expects into
// a scoreboard queue. The queue is popped while bus_en is high, and the
// handshake count, pkt_error and the release state are checked on complete.
module tb_tx_dpdm;

  localparam int MAX = 88;
  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] X = 2'b00;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       s_in;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [1:0] bus_out;
  logic       bus_en;
  logic       busy;
  logic       complete;
  logic       pkt_error;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];

  tx_dpdm #(.MAX_BITS(MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .bus_out   (bus_out),
    .bus_en    (bus_en),
    .busy      (busy),
    .complete  (complete),
    .pkt_error (pkt_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; s_in = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    #13;
    checks++; if (bus_out !== J)      begin errors++; $display("FAIL reset_bus_out got=%b exp=%b", bus_out, J); end
    checks++; if (bus_en !== 1'b0)    begin errors++; $display("FAIL reset_bus_en got=%b exp=0", bus_en); end
    checks++; if (complete !== 1'b0)  begin errors++; $display("FAIL reset_complete got=%b exp=0", complete); end
    checks++; if (pkt_error !== 1'b0) begin errors++; $display("FAIL reset_pkt_error got=%b exp=0", pkt_error); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (s_ready !== 1'b0)   begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus_en !== 1'b0 || bus_out !== J) begin
      errors++; $display("FAIL idle_after_reset got en=%b bus=%b exp en=0 bus=%b", bus_en, bus_out, J);
    end
  endtask

  // Runs one packet. underrun_at: index at which s_valid drops (-1 = never).
  // hold_start keeps start high throughout; mid_pulse pulses start while in DATA.
  task automatic send_packet(input string name, input logic [127:0] bits, input int n,
                             input bit give_last, input int underrun_at, input bit exp_err,
                             input bit hold_start, input bit mid_pulse);
    int bi, acc, exp_acc, en_cycles, exp_en;
    bit done;
    logic [1:0] e;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 1 || i == 3 || i == 5) ? J : K);
    exp_acc = 0;
    for (int k = 0; k < n; k++) begin
      if (k == underrun_at) begin exp_q.push_back(X); break; end
      exp_q.push_back(bits[k] ? J : K);
      exp_acc++;
      if ((give_last && k == n - 1) || exp_acc == MAX) begin exp_q.push_back(X); break; end
    end
    exp_q.push_back(X);
    exp_q.push_back(J);
    exp_en = exp_q.size();

    @(negedge clk);
    bi = 0; acc = 0; en_cycles = 0; done = 0;
    start   = 1'b1;
    s_in    = bits[0];
    s_valid = (n > 0) && (underrun_at != 0);
    s_last  = give_last && (n == 1);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (s_ready && s_valid) begin acc++; bi++; end
      @(negedge clk);
      if (complete) begin
        done = 1;
        checks++; if (pkt_error !== exp_err) begin errors++; $display("FAIL %s pkt_error got=%b exp=%b", name, pkt_error, exp_err); end
        checks++; if (en_cycles != exp_en)   begin errors++; $display("FAIL %s bus_en_cycles got=%0d exp=%0d", name, en_cycles, exp_en); end
        checks++; if (acc != exp_acc)        begin errors++; $display("FAIL %s accepts got=%0d exp=%0d", name, acc, exp_acc); end
        checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL %s symbols_left got=%0d exp=0", name, exp_q.size()); end
        checks++; if (bus_en !== 1'b0 || bus_out !== J || busy !== 1'b0) begin
          errors++; $display("FAIL %s released got en=%b bus=%b busy=%b exp en=0 bus=%b busy=0", name, bus_en, bus_out, busy, J);
        end
      end else if (bus_en) begin
        en_cycles++;
        if (exp_q.size() == 0) begin
          errors++; checks++; $display("FAIL %s extra_symbol got=%b exp=none", name, bus_out);
        end else begin
          e = exp_q.pop_front();
          checks++; if (bus_out !== e) begin errors++; $display("FAIL %s bus_sym%0d got=%b exp=%b", name, en_cycles - 1, bus_out, e); end
        end
      end
      start   = hold_start ? 1'b1 : (mid_pulse && bi == 2 && s_ready);
      s_in    = bits[bi];
      s_valid = (bi < n) && (bi != underrun_at);
      s_last  = give_last && (bi == n - 1);
    end
    if (!done) begin errors++; checks++; $display("FAIL %s timeout got=no_complete exp=complete", name); end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    if (hold_start) begin
      checks++; if (bus_en !== 1'b1 || bus_out !== K || busy !== 1'b1) begin
        errors++; $display("FAIL %s restart got en=%b bus=%b busy=%b exp en=1 bus=%b busy=1", name, bus_en, bus_out, busy, K);
      end
      start = 1'b0;
    end else begin
      checks++; if (complete !== 1'b0 || pkt_error !== 1'b0 || busy !== 1'b0 || bus_en !== 1'b0 || bus_out !== J) begin
        errors++; $display("FAIL %s idle_after got c=%b e=%b busy=%b en=%b bus=%b exp 0 0 0 0 %b",
                           name, complete, pkt_error, busy, bus_en, bus_out, J);
      end
    end
  endtask

  task automatic test_basic();
    send_packet("basic", 128'b01001101, 8, 1'b1, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_bit();
    send_packet("single", 128'b0, 1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_underrun();
    send_packet("underrun", 128'b011, 4, 1'b0, 3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_truncation();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    send_packet("truncation", r, 100, 1'b0, -1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    send_packet("start_mid", 128'hA5C3, 16, 1'b1, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    send_packet("held_start", 128'h3C, 6, 1'b1, -1, 1'b0, 1'b1, 1'b0);
    // Abort the packet that the held start launched.
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int acc;
    @(negedge clk);
    acc = 0;
    start = 1'b1; s_valid = 1'b1; s_last = 1'b0; s_in = 1'b1;
    for (int cyc = 0; cyc < 100 && acc < 20; cyc++) begin
      if (s_ready && s_valid) acc++;
      @(negedge clk);
      start = 1'b0;
      s_in  = 1'($urandom);
    end
    checks++; if (acc != 20) begin errors++; $display("FAIL rst_mid reach_bit20 got=%0d exp=20", acc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_en !== 1'b0 || bus_out !== J) begin
      errors++; $display("FAIL rst_mid immediate got en=%b bus=%b exp en=0 bus=%b", bus_en, bus_out, J);
    end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid state got busy=%b ready=%b exp 0 0", busy, s_ready);
    end
    @(negedge clk); rst_n = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (complete !== 1'b0 || bus_en !== 1'b0) begin
        errors++; $display("FAIL rst_mid no_complete got c=%b en=%b exp 0 0", complete, bus_en);
      end
    end
    send_packet("after_reset", 128'b10, 2, 1'b1, -1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_bit();
    test_underrun();
    test_truncation();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
